// File: rtl/fns_cac_encoder_iter_if.sv
// ---------------------------------------------------------------------------
// fns_cac_encoder_iter_if
//   Handshake bundle between the data source, the FNS encoder and the bus
//   driver side.
//   datain/in_valid/in_ready    : binary word in, valid/ready
//   codeout/out_valid/out_ready : codeword out, valid/ready
//   code_err                    : out-of-range flag (only when
//                                 FNS_ENC_RANGE_CHK_EN is defined)
//   modport slave  : the encoder
//   modport master : the source/sink driving the encoder
// ---------------------------------------------------------------------------
interface fns_cac_encoder_iter_if #(
   parameter int CODE_W = 33,
   parameter int DATA_W = 24
);
   logic [DATA_W-1:0] datain;
   logic              in_valid;
   logic              in_ready;
   logic [CODE_W-1:0] codeout;
   logic              out_valid;
   logic              out_ready;
`ifdef FNS_ENC_RANGE_CHK_EN
   logic              code_err;
`endif

   modport slave (
      input  datain, in_valid, out_ready,
      output in_ready, codeout, out_valid
`ifdef FNS_ENC_RANGE_CHK_EN
      , output code_err
`endif
   );

   modport master (
      output datain, in_valid, out_ready,
      input  in_ready, codeout, out_valid
`ifdef FNS_ENC_RANGE_CHK_EN
      , input code_err
`endif
   );
endinterface

// File: rtl/fns_cac_encoder_iter.sv
// ---------------------------------------------------------------------------
// fns_cac_encoder_iter
//   Iterative Fibonacci-numeral-system crosstalk-avoidance encoder. Converts
//   a DATA_W-bit binary word into a CODE_W-bit codeword free of 010/101
//   patterns, resolving one code bit per clock (MSB first) with a single
//   compare/subtract datapath.
//   Ports:
//     clock_i : clock, all state on posedge
//     reset_i : synchronous, active-high reset
//     bus     : fns_cac_encoder_iter_if.slave (input and output handshakes)
//   Optional feature: define FNS_ENC_RANGE_CHK_EN to add bus.code_err; an
//   input >= F(CODE_W+2) then yields codeout=0 with code_err=1.
// ---------------------------------------------------------------------------
module fns_cac_encoder_iter #(
   parameter int CODE_W = 33,
   parameter int DATA_W = 24
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   fns_cac_encoder_iter_if.slave bus
);
   // Fibonacci with F(1)=F(2)=1
   function automatic logic [63:0] fib(input int n);
      logic [63:0] a, b, t;
      a = 64'd1;
      b = 64'd1;
      for (int i = 3; i <= n; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return b;
   endfunction

   // Code weights: W0=1, Wk=F(k+1)
   function automatic logic [63:0] wgt(input int k);
      return (k == 0) ? 64'd1 : fib(k + 1);
   endfunction

   localparam logic [63:0] F_TOP = fib(CODE_W + 2);
   localparam int WW = $clog2(F_TOP);
   localparam int MW = (WW > DATA_W) ? WW : DATA_W;
   localparam int KW = $clog2(CODE_W);
   localparam int SW = CODE_W - 2;
   localparam logic [WW-1:0] HI0 = WW'(wgt(CODE_W));
   localparam logic [WW-1:0] LO0 = WW'(wgt(CODE_W - 1));

   if (CODE_W < 3) begin : g_bad_code_w
      $error("fns_cac_encoder_iter: CODE_W must be >= 3");
   end
   if (!((64'd1 << (DATA_W - 1)) < F_TOP)) begin : g_bad_data_w
      $error("fns_cac_encoder_iter: 2^(DATA_W-1) must be < F(CODE_W+2)");
   end

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] r_q, r_d, r_nx;
   logic [KW-1:0]     k_q, k_d;
   logic [WW-1:0]     hi_q, hi_d, lo_q, lo_d;
   logic [SW-1:0]     sr_q, sr_d, sr_nx;
   logic [CODE_W-1:0] code_q, code_d;
   logic              bit_c;
`ifdef FNS_ENC_RANGE_CHK_EN
   logic              err_q, err_d, cerr_q, cerr_d;
`endif

   // Bit decision for weight lo=Wk: below Wk forces 0, at/above W(k+1)
   // forces 1, in between repeats the previous (higher) bit, which is what
   // keeps 010/101 out of the codeword. sr_q[0] holds c[k+1] (0 for the top).
   always_comb begin
      bit_c = 1'b0;
      if (MW'(r_q) >= MW'(hi_q))
         bit_c = 1'b1;
      else if (MW'(r_q) >= MW'(lo_q))
         bit_c = sr_q[0];
      r_nx  = bit_c ? (r_q - DATA_W'(lo_q)) : r_q;
      sr_nx = (sr_q << 1) | SW'(bit_c);
   end

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      k_d     = k_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      sr_d    = sr_q;
      code_d  = code_q;
`ifdef FNS_ENC_RANGE_CHK_EN
      err_d   = err_q;
      cerr_d  = cerr_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               r_d     = bus.datain;
               k_d     = KW'(CODE_W - 1);
               hi_d    = HI0;
               lo_d    = LO0;
               sr_d    = '0;
`ifdef FNS_ENC_RANGE_CHK_EN
               err_d   = (64'(bus.datain) >= F_TOP);
`endif
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            r_d  = r_nx;
            sr_d = sr_nx;
            hi_d = lo_q;
            lo_d = hi_q - lo_q;
            k_d  = k_q - KW'(1);
            if (k_q == KW'(1)) begin
               // last step: c[0] is the leftover remainder (0 or 1)
               code_d  = {sr_q, bit_c, r_nx[0]};
`ifdef FNS_ENC_RANGE_CHK_EN
               if (err_q) code_d = '0;
               cerr_d  = err_q;
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
`ifdef FNS_ENC_RANGE_CHK_EN
               cerr_d  = 1'b0;
`endif
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         r_q     <= '0;
         k_q     <= '0;
         hi_q    <= HI0;
         lo_q    <= LO0;
         sr_q    <= '0;
         code_q  <= '0;
`ifdef FNS_ENC_RANGE_CHK_EN
         err_q   <= 1'b0;
         cerr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         k_q     <= k_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         sr_q    <= sr_d;
         code_q  <= code_d;
`ifdef FNS_ENC_RANGE_CHK_EN
         err_q   <= err_d;
         cerr_q  <= cerr_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == IDLE) && !reset_i;
   assign bus.out_valid = (state_q == DONE);
   assign bus.codeout   = code_q;
`ifdef FNS_ENC_RANGE_CHK_EN
   assign bus.code_err  = cerr_q;
`endif
endmodule
